// File: rtl/datapath_sequencer.sv
// datapath_sequencer
// Multi-cycle control FSM for the MkII datapath. It accepts one encoded
// instruction at a time and expands it into a fixed sequence of
// single-driver bus cycles. Every datapath strobe is a registered (Moore)
// output, derived from the FSM state and the latched instruction.
//
// Handshake: an instruction transfers on a rising clk edge where
// instr_valid && instr_ready. instr_ready is high exactly when the FSM is
// IDLE. instr is sampled only on that edge. instr_valid seen while
// instr_ready is low is ignored.
//
// Instruction fields:
//   op = [31:27], rd = [26:22], rs1 = [21:17], use_imm = [16], rs2 = [15:11]
//   imm field = [IMM_W-1:0]; it overlaps rs2 and is sign-extended to 32 bits.
// Op classes:
//   0 = NOP, 1..13 = ALU (op is the ALU function),
//   14 = LI, 15..31 = illegal.
//
// Optional feature: define SEQ_RETIRE_COUNT_EN to add the 32-bit
// retired_count output. It counts done pulses and wraps.
//
// state_dbg shows the current FSM state encoding.
module datapath_sequencer #(
    parameter int IMM_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [4:0]  alu_function_sel,
    output logic        alu_store_1,
    output logic        alu_store_2,
    output logic        alu_broadcast,
    output logic [4:0]  register_index,
    output logic        register_read_enable,
    output logic        register_write_enable,
    output logic [31:0] imm,
    output logic        imm_EN,
    output logic [2:0]  state_dbg
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [31:0] retired_count
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WRITE  = 3'd3,
        LOAD_I = 3'd4
    } state_t;

    localparam logic [4:0] OP_NOP     = 5'd0;
    localparam logic [4:0] OP_ALU_MAX = 5'd13;
    localparam logic [4:0] OP_LI      = 5'd14;

    state_t      state;
    logic [31:0] instr_q;

    // Fields of the incoming instruction, used only on the accept edge.
    logic [4:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [31:0] in_imm_sext;

    // Fields of the latched instruction, used in the later states.
    logic [4:0]  q_op;
    logic [4:0]  q_rd;
    logic [4:0]  q_rs2;
    logic        q_use_imm;
    logic [31:0] q_imm_sext;

    // Decode the incoming and latched instruction words.
    always_comb begin
        in_op       = instr[31:27];
        in_rd       = instr[26:22];
        in_rs1      = instr[21:17];
        in_imm_sext = {{(32-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
        q_op        = instr_q[31:27];
        q_rd        = instr_q[26:22];
        q_use_imm   = instr_q[16];
        q_rs2       = instr_q[15:11];
        q_imm_sext  = {{(32-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};
    end

    assign state_dbg = state;

    // Sequence the FSM. Each branch registers the strobes for the state it enters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            instr_q               <= 32'd0;
            instr_ready           <= 1'b1;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            illegal               <= 1'b0;
            alu_function_sel      <= 5'd0;
            alu_store_1           <= 1'b0;
            alu_store_2           <= 1'b0;
            alu_broadcast         <= 1'b0;
            register_index        <= 5'd0;
            register_read_enable  <= 1'b0;
            register_write_enable <= 1'b0;
            imm                   <= 32'd0;
            imm_EN                <= 1'b0;
        end else begin
            // Pulses and strobes last one cycle unless the next state sets them.
            done                  <= 1'b0;
            illegal               <= 1'b0;
            alu_function_sel      <= 5'd0;
            alu_store_1           <= 1'b0;
            alu_store_2           <= 1'b0;
            alu_broadcast         <= 1'b0;
            register_index        <= 5'd0;
            register_read_enable  <= 1'b0;
            register_write_enable <= 1'b0;
            imm                   <= 32'd0;
            imm_EN                <= 1'b0;

            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        if (in_op == OP_NOP) begin
                            // NOP retires at once and leaves the FSM in IDLE.
                            done <= 1'b1;
                        end else if (in_op <= OP_ALU_MAX) begin
                            // Enter LOAD_A: read rs1 into ALU operand 1.
                            state                <= LOAD_A;
                            instr_ready          <= 1'b0;
                            busy                 <= 1'b1;
                            register_index       <= in_rs1;
                            register_read_enable <= 1'b1;
                            alu_store_1          <= 1'b1;
                        end else if (in_op == OP_LI) begin
                            // Enter LOAD_I: the immediate drives the bus into rd.
                            state                 <= LOAD_I;
                            instr_ready           <= 1'b0;
                            busy                  <= 1'b1;
                            imm                   <= in_imm_sext;
                            imm_EN                <= 1'b1;
                            register_index        <= in_rd;
                            register_write_enable <= 1'b1;
                            done                  <= 1'b1;
                        end else begin
                            // Illegal op: report it and assert no datapath strobe.
                            illegal <= 1'b1;
                        end
                    end
                end

                LOAD_A: begin
                    // Enter LOAD_B: operand 2 comes from rs2 or the immediate.
                    state       <= LOAD_B;
                    alu_store_2 <= 1'b1;
                    if (q_use_imm) begin
                        imm    <= q_imm_sext;
                        imm_EN <= 1'b1;
                    end else begin
                        register_index       <= q_rs2;
                        register_read_enable <= 1'b1;
                    end
                end

                LOAD_B: begin
                    // Enter WRITE: the ALU drives the bus and rd captures it.
                    // rd = 0 is still written; the datapath discards it.
                    state                 <= WRITE;
                    alu_function_sel      <= q_op;
                    alu_broadcast         <= 1'b1;
                    register_index        <= q_rd;
                    register_write_enable <= 1'b1;
                    done                  <= 1'b1;
                end

                WRITE, LOAD_I: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_RETIRE_COUNT_EN
    // Count retired instructions, including NOPs. Illegal ops are not counted,
    // and the count wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= 32'd0;
        end else if (done) begin
            retired_count <= retired_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer
// Directed bench for datapath_sequencer. The driver issues instructions and
// pushes hand-computed control words into exp_q. A negedge monitor pops and
// compares a word whenever the DUT is busy or pulses done/illegal. The monitor
// also runs a small register-file/ALU model from the strobes, so final
// register values can be checked against constants.
module tb_datapath_sequencer;

    localparam int CW = 50;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [4:0]  alu_function_sel;
    logic        alu_store_1;
    logic        alu_store_2;
    logic        alu_broadcast;
    logic [4:0]  register_index;
    logic        register_read_enable;
    logic        register_write_enable;
    logic [31:0] imm;
    logic        imm_EN;
    logic [2:0]  state_dbg;
`ifdef SEQ_RETIRE_COUNT_EN
    logic [31:0] retired_count;
    logic [31:0] exp_cnt;
`endif

    int checks;
    int failures;
    int cyc;
    int acc_cyc;
    int done_cyc;

    logic [CW-1:0] exp_q[$];

    // Register-file / ALU model, driven by the DUT strobes.
    logic [31:0] regs [32];
    logic [31:0] a_lat;
    logic [31:0] b_lat;

    datapath_sequencer #(.IMM_W(16)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .instr                 (instr),
        .instr_valid           (instr_valid),
        .instr_ready           (instr_ready),
        .busy                  (busy),
        .done                  (done),
        .illegal               (illegal),
        .alu_function_sel      (alu_function_sel),
        .alu_store_1           (alu_store_1),
        .alu_store_2           (alu_store_2),
        .alu_broadcast         (alu_broadcast),
        .register_index        (register_index),
        .register_read_enable  (register_read_enable),
        .register_write_enable (register_write_enable),
        .imm                   (imm),
        .imm_EN                (imm_EN),
        .state_dbg             (state_dbg)
`ifdef SEQ_RETIRE_COUNT_EN
        ,
        .retired_count         (retired_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic logic [CW-1:0] cw(input logic dn, input logic il, input logic [4:0] fs,
                                         input logic s1, input logic s2, input logic bc,
                                         input logic [4:0] ix, input logic re, input logic we,
                                         input logic [31:0] im, input logic ie);
        return {dn, il, fs, s1, s2, bc, ix, re, we, im, ie};
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic ui,
                                        input logic [15:0] low);
        return {op, rd, rs1, ui, low};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Hold instr_valid with junk on instr until ready, then present the real word.
    task automatic send(input logic [31:0] ins);
        int n;
        n = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            instr = $urandom;
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=ready_low required=ready_high instr=%h", ins);
            instr_valid = 1'b0;
        end else begin
            instr   = ins;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
            instr       = $urandom;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (busy || exp_q.size() != 0) begin
            failures++;
            $display("FAIL idle_timeout actual=busy%0d_q%0d required=idle_q0", busy, exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Sample at negedge: compare the control word, the bus rule and the ready/busy relation.
    always @(negedge clk) begin
        logic [CW-1:0] act;
        logic [CW-1:0] e;
        logic [31:0]   bus;
        logic [31:0]   alu;
        if (!reset) begin
            act = {done, illegal, alu_function_sel, alu_store_1, alu_store_2, alu_broadcast,
                   register_index, register_read_enable, register_write_enable, imm, imm_EN};

            checks++;
            if ($countones({alu_broadcast, register_read_enable, imm_EN}) != (busy ? 1 : 0)) begin
                failures++;
                $display("FAIL bus_onehot actual=%b required=%0d_driver busy=%0d",
                         {alu_broadcast, register_read_enable, imm_EN}, busy ? 1 : 0, busy);
            end

            checks++;
            if (instr_ready !== !busy) begin
                failures++;
                $display("FAIL ready_vs_busy actual=ready%0d required=%0d", instr_ready, !busy);
            end

            if (busy || done || illegal) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=none", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        failures++;
                        $display("FAIL ctrl_word actual=%h required=%h", act, e);
                    end
                end
            end else begin
                checks++;
                if (act !== '0) begin
                    failures++;
                    $display("FAIL idle_strobes actual=%h required=0", act);
                end
            end

            if (done) done_cyc = cyc;

`ifdef SEQ_RETIRE_COUNT_EN
            checks++;
            if (retired_count !== exp_cnt) begin
                failures++;
                $display("FAIL retired_count actual=%h required=%h", retired_count, exp_cnt);
            end
            if (done) exp_cnt = exp_cnt + 32'd1;
`endif

            // Datapath model: ALU function 12 = ADD, 13 = SUB.
            alu = (alu_function_sel == 5'd12) ? a_lat + b_lat :
                  (alu_function_sel == 5'd13) ? a_lat - b_lat : 32'd0;
            bus = register_read_enable ? regs[register_index] :
                  imm_EN               ? imm :
                  alu_broadcast        ? alu : 32'd0;
            if (alu_store_1) a_lat = bus;
            if (alu_store_2) b_lat = bus;
            if (register_write_enable) regs[register_index] = bus;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int a0, a1, a2;
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        acc_cyc     = 0;
        done_cyc    = 0;
        a_lat       = 32'd0;
        b_lat       = 32'd0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1]     = 32'd10;
        reset       = 1'b1;
        instr       = 32'd0;
        instr_valid = 1'b0;
`ifdef SEQ_RETIRE_COUNT_EN
        exp_cnt     = 32'd0;
`endif

        #1;
        check32("reset_ctrl",
                {done, illegal, alu_function_sel, alu_store_1, alu_store_2, alu_broadcast,
                 register_index, register_read_enable, register_write_enable, imm[15:0], imm_EN},
                32'd0);
        check32("reset_imm", imm, 32'd0);
        check32("reset_ready_busy_state", {27'd0, instr_ready, busy, state_dbg}, {27'd0, 1'b1, 1'b0, 3'd0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // LI r3, 0xFFF0 -> imm sign-extends to 0xFFFFFFF0.
        send(enc(5'd14, 5'd3, 5'd0, 1'b0, 16'hFFF0));
        exp_q.push_back(cw(1, 0, 5'd0, 0, 0, 0, 5'd3, 0, 1, 32'hFFFF_FFF0, 1));

        // ADD r5 <- r3 + r3 (rs2 = 3 sits in bits [15:11]).
        send(enc(5'd12, 5'd5, 5'd3, 1'b0, {5'd3, 11'd0}));
        a0 = acc_cyc;
        exp_q.push_back(cw(0, 0, 5'd0,  1, 0, 0, 5'd3, 1, 0, 32'd0, 0));
        exp_q.push_back(cw(0, 0, 5'd0,  0, 1, 0, 5'd3, 1, 0, 32'd0, 0));
        exp_q.push_back(cw(1, 0, 5'd12, 0, 0, 1, 5'd5, 0, 1, 32'd0, 0));
        wait_idle();
        check32("add_done_latency", done_cyc - a0, 32'd3);
        check32("li_r3", regs[3], 32'hFFFF_FFF0);
        check32("add_r5", regs[5], 32'hFFFF_FFE0);

        // SUB r2 <- r1 - imm 5, with r1 = 10.
        send(enc(5'd13, 5'd2, 5'd1, 1'b1, 16'd5));
        exp_q.push_back(cw(0, 0, 5'd0,  1, 0, 0, 5'd1, 1, 0, 32'd0, 0));
        exp_q.push_back(cw(0, 0, 5'd0,  0, 1, 0, 5'd0, 0, 0, 32'd5, 1));
        exp_q.push_back(cw(1, 0, 5'd13, 0, 0, 1, 5'd2, 0, 1, 32'd0, 0));
        wait_idle();
        check32("sub_r2", regs[2], 32'd5);

        // Back-to-back ALU stream: op 1 (rd 0), op 13 with a negative immediate, op 7.
        send(enc(5'd1, 5'd0, 5'd1, 1'b0, {5'd2, 11'd0}));
        a0 = acc_cyc;
        exp_q.push_back(cw(0, 0, 5'd0, 1, 0, 0, 5'd1, 1, 0, 32'd0, 0));
        exp_q.push_back(cw(0, 0, 5'd0, 0, 1, 0, 5'd2, 1, 0, 32'd0, 0));
        exp_q.push_back(cw(1, 0, 5'd1, 0, 0, 1, 5'd0, 0, 1, 32'd0, 0));
        send(enc(5'd13, 5'd4, 5'd1, 1'b1, 16'h8000));
        a1 = acc_cyc;
        exp_q.push_back(cw(0, 0, 5'd0,  1, 0, 0, 5'd1, 1, 0, 32'd0, 0));
        exp_q.push_back(cw(0, 0, 5'd0,  0, 1, 0, 5'd0, 0, 0, 32'hFFFF_8000, 1));
        exp_q.push_back(cw(1, 0, 5'd13, 0, 0, 1, 5'd4, 0, 1, 32'd0, 0));
        send(enc(5'd7, 5'd6, 5'd2, 1'b0, {5'd31, 11'd0}));
        a2 = acc_cyc;
        exp_q.push_back(cw(0, 0, 5'd0, 1, 0, 0, 5'd2,  1, 0, 32'd0, 0));
        exp_q.push_back(cw(0, 0, 5'd0, 0, 1, 0, 5'd31, 1, 0, 32'd0, 0));
        exp_q.push_back(cw(1, 0, 5'd7, 0, 0, 1, 5'd6,  0, 1, 32'd0, 0));
        check32("stream_gap_1", a1 - a0, 32'd4);
        check32("stream_gap_2", a2 - a1, 32'd4);
        wait_idle();
        check32("sub_neg_imm_r4", regs[4], 32'h0000_800A);

        // Illegal op 20 followed immediately by a NOP.
        send(enc(5'd20, 5'd1, 5'd1, 1'b0, 16'h1234));
        a0 = acc_cyc;
        exp_q.push_back(cw(0, 1, 5'd0, 0, 0, 0, 5'd0, 0, 0, 32'd0, 0));
        send(32'd0);
        a1 = acc_cyc;
        exp_q.push_back(cw(1, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 32'd0, 0));
        check32("nop_after_illegal_gap", a1 - a0, 32'd1);

        // Boundaries of the illegal range: op 15 and op 31.
        send(enc(5'd15, 5'd2, 5'd0, 1'b1, 16'hFFFF));
        exp_q.push_back(cw(0, 1, 5'd0, 0, 0, 0, 5'd0, 0, 0, 32'd0, 0));
        send(enc(5'd31, 5'd31, 5'd31, 1'b1, 16'hFFFF));
        exp_q.push_back(cw(0, 1, 5'd0, 0, 0, 0, 5'd0, 0, 0, 32'd0, 0));
        wait_idle();
        check32("illegal_no_write_r2", regs[2], 32'd5);

        // Reset during LOAD_B of SUB r7 <- r1 - 3 aborts it; r7 stays 0.
        send(enc(5'd13, 5'd7, 5'd1, 1'b1, 16'd3));
        exp_q.push_back(cw(0, 0, 5'd0,  1, 0, 0, 5'd1, 1, 0, 32'd0, 0));
        exp_q.push_back(cw(0, 0, 5'd0,  0, 1, 0, 5'd0, 0, 0, 32'd3, 1));
        exp_q.push_back(cw(1, 0, 5'd13, 0, 0, 1, 5'd7, 0, 1, 32'd0, 0));
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
`ifdef SEQ_RETIRE_COUNT_EN
        exp_cnt = 32'd0;
`endif
        #1;
        check32("abort_ctrl",
                {done, illegal, alu_function_sel, alu_store_1, alu_store_2, alu_broadcast,
                 register_index, register_read_enable, register_write_enable, imm[15:0], imm_EN},
                32'd0);
        check32("abort_imm", imm, 32'd0);
        check32("abort_ready_busy_state", {27'd0, instr_ready, busy, state_dbg}, {27'd0, 1'b1, 1'b0, 3'd0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check32("abort_no_write_r7", regs[7], 32'd0);

        // Recovery after the abort: LI r9, 0x1234.
        send(enc(5'd14, 5'd9, 5'd0, 1'b0, 16'h1234));
        exp_q.push_back(cw(1, 0, 5'd0, 0, 0, 0, 5'd9, 0, 1, 32'h0000_1234, 1));
        wait_idle();
        check32("li_r9", regs[9], 32'h0000_1234);

`ifdef SEQ_RETIRE_COUNT_EN
        // Counter wrap: force it to all-ones while idle, then retire a NOP.
        @(posedge clk);
        #2;
        force dut.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count;
        exp_cnt = 32'hFFFF_FFFF;
        send(32'd0);
        exp_q.push_back(cw(1, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 32'd0, 0));
        wait_idle();
        check32("retired_wrap", retired_count, 32'd0);
`endif

        check32("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
